// File: rtl/sync_fifo_ff_pkg.sv
// Shared defaults for the flip-flop FWFT FIFO and its bus interface.
package sync_fifo_ff_pkg;

    localparam int DW_DEF   = 18;
    localparam int AW_DEF   = 8;
    localparam int FOFF_DEF = 64;

endpackage

// File: rtl/sync_fifo_ff_if.sv
// Write/read/status bundle of the FWFT FIFO; the FIFO is the slave, the producer/consumer side the master.
interface sync_fifo_ff_if
    import sync_fifo_ff_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) ();

    logic          WR_REQ;
    logic [DW-1:0] WR_DI;
    logic          RD_REQ;
    logic [DW-1:0] RD_DO;
    logic [AW:0]   DEPTH;
    logic          EMPTY;
    logic          FULL;
    logic          AFULL;

    modport master (
        output WR_REQ, WR_DI, RD_REQ,
        input  RD_DO, DEPTH, EMPTY, FULL, AFULL
    );

    modport slave (
        input  WR_REQ, WR_DI, RD_REQ,
        output RD_DO, DEPTH, EMPTY, FULL, AFULL
    );

endinterface

// File: rtl/sync_fifo_ff.sv
// Single-clock register-array FIFO with first-word-fall-through head and occupancy flags.
module sync_fifo_ff
    import sync_fifo_ff_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF,
    parameter int FOFF = FOFF_DEF
) (
    input  logic           iCLK,
    input  logic           iRSTN,
    input  logic           INIT,
    sync_fifo_ff_if.slave  bus
);

    localparam logic [AW:0]   DEPTH_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   AFULL_TH  = DEPTH_MAX - (AW+1)'(FOFF);
    localparam logic [AW:0]   DEPTH_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

    logic [DW-1:0] mem_r [2**AW];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   depth_r;

    logic          empty_s;
    logic          full_s;
    logic          afull_s;
    logic          wr_ok_s;
    logic          rd_ok_s;

    // Flags and effective-transfer qualifiers, all derived from the registered count.
    always_comb begin
        empty_s = (depth_r == {(AW+1){1'b0}});
        full_s  = (depth_r == DEPTH_MAX);
        afull_s = (depth_r >= AFULL_TH);
        // A write into a full FIFO is still legal when the head leaves in the same cycle.
        wr_ok_s = bus.WR_REQ & (~full_s | bus.RD_REQ);
        rd_ok_s = bus.RD_REQ & ~empty_s;
    end

    // Storage array; deliberately not reset so clears only move pointers.
    always_ff @(posedge iCLK) begin
        if (!INIT && wr_ok_s) begin
            mem_r[wr_ptr_r] <= bus.WR_DI;
        end
    end

    // Read and write pointers, wrapping naturally at the array size.
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else if (INIT) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Occupancy counter; simultaneous accepted write and read cancel out.
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            depth_r <= {(AW+1){1'b0}};
        end else if (INIT) begin
            depth_r <= {(AW+1){1'b0}};
        end else begin
            case ({wr_ok_s, rd_ok_s})
                2'b10:   depth_r <= depth_r + DEPTH_ONE;
                2'b01:   depth_r <= depth_r - DEPTH_ONE;
                default: depth_r <= depth_r;
            endcase
        end
    end

    assign bus.RD_DO = mem_r[rd_ptr_r];
    assign bus.DEPTH = depth_r;
    assign bus.EMPTY = empty_s;
    assign bus.FULL  = full_s;
    assign bus.AFULL = afull_s;

endmodule

// File: tb/tb_sync_fifo_ff.sv
// Self-checking bench for sync_fifo_ff: directed boundary cases plus random traffic against a queue model.
module tb_sync_fifo_ff;

    localparam int DW   = 18;
    localparam int AW   = 8;
    localparam int FOFF = 64;
    localparam int CAP  = 2**AW;

    logic iCLK  = 1'b0;
    logic iRSTN = 1'b0;
    logic INIT  = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] model_q [$];

    sync_fifo_ff_if #(.DW(DW), .AW(AW)) bus ();

    sync_fifo_ff #(.DW(DW), .AW(AW), .FOFF(FOFF)) dut (
        .iCLK  (iCLK),
        .iRSTN (iRSTN),
        .INIT  (INIT),
        .bus   (bus)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output against the queue model.
    task automatic check_state();
        chk("depth", 32'(bus.DEPTH), model_q.size());
        chk("empty", 32'(bus.EMPTY), (model_q.size() == 0) ? 1 : 0);
        chk("full",  32'(bus.FULL),  (model_q.size() == CAP) ? 1 : 0);
        chk("afull", 32'(bus.AFULL), (model_q.size() >= CAP - FOFF) ? 1 : 0);
        if (model_q.size() > 0) chk("rd_do", 32'(bus.RD_DO), 32'(model_q[0]));
    endtask

    // One clock cycle: called at a falling edge, returns at the next falling edge after checking.
    task automatic step(input logic wr, input logic rd, input logic init, input logic [DW-1:0] di);
        bit full_m;
        bit wr_ok;
        bit rd_ok;
        bus.WR_REQ = wr;
        bus.RD_REQ = rd;
        bus.WR_DI  = di;
        INIT       = init;
        @(posedge iCLK);
        full_m = (model_q.size() == CAP);
        wr_ok  = wr && (!full_m || rd);
        rd_ok  = rd && (model_q.size() > 0);
        if (init) begin
            model_q.delete();
        end else begin
            if (rd_ok) void'(model_q.pop_front());
            if (wr_ok) model_q.push_back(di);
        end
        @(negedge iCLK);
        check_state();
    endtask

    task automatic async_reset();
        bus.WR_REQ = 1'b0;
        bus.RD_REQ = 1'b0;
        INIT       = 1'b0;
        #1 iRSTN = 1'b0;
        #1;
        chk("arst_depth", 32'(bus.DEPTH), 0);
        chk("arst_empty", 32'(bus.EMPTY), 1);
        #1 iRSTN = 1'b1;
        model_q.delete();
        @(negedge iCLK);
        check_state();
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, DW'(base + i));
    endtask

    initial begin
        bus.WR_REQ = 1'b0;
        bus.RD_REQ = 1'b0;
        bus.WR_DI  = '0;
        repeat (2) @(negedge iCLK);
        chk("rst_depth", 32'(bus.DEPTH), 0);
        chk("rst_empty", 32'(bus.EMPTY), 1);
        chk("rst_full",  32'(bus.FULL),  0);
        chk("rst_afull", 32'(bus.AFULL), 0);
        iRSTN = 1'b1;
        @(negedge iCLK);

        // Basic write then pop of five words.
        step(1'b1, 1'b0, 1'b0, 18'h00001);
        chk("t1_empty_after_first", 32'(bus.EMPTY), 0);
        chk("t1_head_after_first", 32'(bus.RD_DO), 32'h1);
        for (int i = 2; i <= 5; i++) step(1'b1, 1'b0, 1'b0, DW'(i));
        chk("t1_depth5", 32'(bus.DEPTH), 5);
        for (int i = 1; i <= 5; i++) begin
            chk("t1_pop", 32'(bus.RD_DO), i);
            step(1'b0, 1'b1, 1'b0, '0);
        end
        chk("t1_empty_end", 32'(bus.EMPTY), 1);
        chk("t1_depth_end", 32'(bus.DEPTH), 0);

        // Almost-full threshold, full, dropped overflow write.
        fill(191, 0);
        chk("t2_afull_191", 32'(bus.AFULL), 0);
        step(1'b1, 1'b0, 1'b0, DW'(191));
        chk("t2_afull_192", 32'(bus.AFULL), 1);
        fill(64, 192);
        chk("t2_full", 32'(bus.FULL), 1);
        step(1'b1, 1'b0, 1'b0, 18'h2AAAA);
        chk("t2_depth_after_drop", 32'(bus.DEPTH), 256);
        for (int i = 0; i < CAP; i++) begin
            chk("t2_pop", 32'(bus.RD_DO), i);
            step(1'b0, 1'b1, 1'b0, '0);
        end
        chk("t2_empty", 32'(bus.EMPTY), 1);

        // Simultaneous write and read while full.
        fill(CAP, 0);
        for (int i = 0; i < 10; i++) begin
            chk("t3_pop_oldest", 32'(bus.RD_DO), i);
            step(1'b1, 1'b1, 1'b0, DW'(1000 + i));
            chk("t3_depth_full", 32'(bus.DEPTH), 256);
        end
        for (int i = 0; i < CAP; i++) step(1'b0, 1'b1, 1'b0, '0);
        chk("t3_drained", 32'(bus.EMPTY), 1);

        // Write and read together on an empty FIFO, then a lone read on empty.
        step(1'b1, 1'b1, 1'b0, 18'h3ABCD);
        chk("t4_depth1", 32'(bus.DEPTH), 1);
        chk("t4_head", 32'(bus.RD_DO), 32'h3ABCD);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("t4_underflow_depth", 32'(bus.DEPTH), 0);

        // Synchronous clear with a concurrent write, then asynchronous reset mid-traffic.
        fill(100, 500);
        step(1'b1, 1'b0, 1'b1, 18'h11111);
        chk("t5_init_depth", 32'(bus.DEPTH), 0);
        chk("t5_init_empty", 32'(bus.EMPTY), 1);
        chk("t5_init_afull", 32'(bus.AFULL), 0);
        step(1'b1, 1'b0, 1'b0, 18'h12345);
        chk("t5_init_new", 32'(bus.RD_DO), 32'h12345);
        step(1'b0, 1'b1, 1'b0, '0);
        fill(100, 700);
        async_reset();
        step(1'b1, 1'b0, 1'b0, 18'h23456);
        chk("t5_arst_new", 32'(bus.RD_DO), 32'h23456);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("t5_arst_empty", 32'(bus.EMPTY), 1);

        // Random traffic at three write densities, with occasional clears.
        for (int d = 1; d <= 7; d += 3) begin
            for (int c = 0; c < 6000; c++) begin
                step(($urandom_range(7) < d) ? 1'b1 : 1'b0,
                     ($urandom_range(7) < (8 - d)) ? 1'b1 : 1'b0,
                     ($urandom_range(1023) == 0) ? 1'b1 : 1'b0,
                     DW'($urandom));
            end
            for (int c = 0; c < 3000; c++) begin
                step(($urandom_range(7) < d) ? 1'b1 : 1'b0,
                     ($urandom_range(7) < d) ? 1'b1 : 1'b0,
                     1'b0, DW'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
